// File: rtl/seq_oka_mult.sv
// Sequential GF(2) multiplier built on a one-level odd/even Karatsuba-Ofman split.
// A single H x H carry-less sub-multiplier is reused over three cycles. It forms
// ae*be, then ao*bo, then (ae^ao)*(be^bo). The final cycle recombines the three
// sub-products into the unreduced 2N-1 bit product.
module seq_oka_mult #(
  parameter int N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy
);

  localparam int H = N / 2;

  // The odd/even split only works for even operand widths, and the
  // zero-extension below needs at least two bits per half.
  generate
    if ((N % 2) != 0 || N < 4) begin : g_bad_width
      $error("seq_oka_mult: N must be even and at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, DONE} state_t;

  state_t           state, next_state;
  logic [N-1:0]     a_reg, b_reg;
  logic [H-1:0]     ae, ao, be, bo;
  logic [H-1:0]     mul_x, mul_y;
  logic [N-2:0]     mul_y_ext, mul_p;
  logic [N-2:0]     p1_reg, p2_reg, mid;
  logic [2*N-2:0]   y_reg, recomb;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign y         = y_reg;
  assign accept    = in_valid & in_ready;

  // Split the captured operands into even-index and odd-index halves.
  always_comb begin
    ae = '0;
    ao = '0;
    be = '0;
    bo = '0;
    for (int j = 0; j < H; j++) begin
      ae[j] = a_reg[2*j];
      ao[j] = a_reg[2*j+1];
      be[j] = b_reg[2*j];
      bo[j] = b_reg[2*j+1];
    end
  end

  // Steer the shared sub-multiplier inputs according to the current step.
  always_comb begin
    mul_x = ae ^ ao;
    mul_y = be ^ bo;
    case (state)
      MUL1: begin
        mul_x = ae;
        mul_y = be;
      end
      MUL2: begin
        mul_x = ao;
        mul_y = bo;
      end
      default: begin
      end
    endcase
  end

  // The one shared H x H carry-less multiplier (shift and XOR).
  always_comb begin
    mul_y_ext = {{(N-1-H){1'b0}}, mul_y};
    mul_p     = '0;
    for (int i = 0; i < H; i++) begin
      if (mul_x[i]) begin
        mul_p = mul_p ^ (mul_y_ext << i);
      end
    end
  end

  // Interleave P1, the middle term and P2 back into the full-width product.
  // In MUL3 the multiplier output is P3.
  always_comb begin
    mid    = p1_reg ^ p2_reg ^ mul_p;
    recomb = '0;
    for (int i = 0; i < N-1; i++) begin
      recomb[2*i]   = recomb[2*i]   ^ p1_reg[i];
      recomb[2*i+1] = recomb[2*i+1] ^ mid[i];
      recomb[2*i+2] = recomb[2*i+2] ^ p2_reg[i];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: three multiply steps, then wait in DONE for the consumer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = MUL1;
      MUL1:    next_state = MUL2;
      MUL2:    next_state = MUL3;
      MUL3:    next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. Operands are captured only on accept and are held
  // until the next accept. y keeps its value after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      p1_reg <= '0;
      p2_reg <= '0;
      y_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        MUL1:    p1_reg <= mul_p;
        MUL2:    p2_reg <= mul_p;
        MUL3:    y_reg  <= recomb;
        default: begin
        end
      endcase
    end
  end

endmodule
